// File: rtl/io_wr_pkg.sv
// -----------------------------------------------------------------------------
// io_wr_pkg
// Shared widths, region constants, state encoding and the region decode helper
// for the datapath write demultiplexer (io_wr_demux) and its FIFO (wr_fifo).
// -----------------------------------------------------------------------------
package io_wr_pkg;

    localparam int REGION_W = 6;                    // WrAddr[15:10]
    localparam int ADDR_W   = 10;                   // memory word address
    localparam int DATA_W   = 16;                   // write data
    localparam int WADDR_W  = REGION_W + ADDR_W;    // full datapath address
    localparam int ENTRY_W  = WADDR_W + DATA_W;     // one buffered write

    localparam logic [REGION_W-1:0] IO_REGION_DEF = 6'h3F;
    localparam logic [REGION_W-1:0] MEM_REGION    = 6'h00;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DEST_MEM = 2'd0,
        DEST_IO  = 2'd1,
        DEST_ERR = 2'd2
    } dest_t;

    typedef struct packed {
        logic [WADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
    } wr_entry_t;

    // Memory region is checked first, so it cannot be shadowed by the IO region.
    function automatic dest_t decode_region(input logic [REGION_W-1:0] region,
                                            input logic [REGION_W-1:0] io_region);
        dest_t dest;
        if (region == MEM_REGION) begin
            dest = DEST_MEM;
        end else if (region == io_region) begin
            dest = DEST_IO;
        end else begin
            dest = DEST_ERR;
        end
        return dest;
    endfunction

endpackage

// File: rtl/wr_fifo.sv
// -----------------------------------------------------------------------------
// wr_fifo
// Small synchronous FIFO holding buffered datapath writes.
//   clk   : clock, all state updates on its rising edge
//   reset : synchronous active-high flush (count and pointers to zero)
//   push  : write din (ignored while full)
//   pop   : discard head entry (ignored while empty)
//   din   : entry to store
//   dout  : current head entry (valid while count != 0)
//   count : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module wr_fifo
    import io_wr_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W + 1)'(1'b0);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against full/empty so count can never leave 0..DEPTH.
    always_comb begin
        push_ok_s = push && (count_r != CNT_FULL);
        pop_ok_s  = pop  && (count_r != CNT_ZERO);
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/io_wr_demux.sv
// -----------------------------------------------------------------------------
// io_wr_demux
// Buffers datapath writes and routes each one, strictly in order, to either a
// handshaked memory port (region 0), a single IO output register (IO_REGION),
// or drops it and raises a sticky address error (any other region).
//   CLK, Reset         : clock and synchronous active-high reset
//   WrValid/WrReady    : write request handshake; WrAddr/WrData are the payload
//   MemAddr/MemData    : memory word address and data, held during MemWe
//   MemWe/MemAck       : memory write request, held until acknowledged
//   IOOut/IOStrobe     : IO output register and its one-cycle update pulse
//   AddrErr/ErrClr     : sticky unmapped-address flag and its clear
// -----------------------------------------------------------------------------
module io_wr_demux
    import io_wr_pkg::*;
#(
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [REGION_W-1:0]   IO_REGION  = IO_REGION_DEF
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 WrValid,
    output logic                 WrReady,
    input  logic [WADDR_W-1:0]   WrAddr,
    input  logic [DATA_W-1:0]    WrData,
    output logic [ADDR_W-1:0]    MemAddr,
    output logic [DATA_W-1:0]    MemData,
    output logic                 MemWe,
    input  logic                 MemAck,
    output logic [DATA_W-1:0]    IOOut,
    output logic                 IOStrobe,
    output logic                 AddrErr,
    input  logic                 ErrClr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [CNT_W-1:0]   count_s;
    logic [ENTRY_W-1:0] head_vec_s;
    logic [ENTRY_W-1:0] push_vec_s;
    wr_entry_t          head_s;
    dest_t              head_dest_s;
    logic               wr_ready_s;
    logic               push_s;
    logic               pop_s;
    logic               empty_s;
    logic               err_set_s;

    state_t             state_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [DATA_W-1:0]  mem_data_r;
    logic               mem_we_r;
    logic [DATA_W-1:0]  io_out_r;
    logic               io_strobe_r;
    logic               addr_err_r;

    assign push_vec_s = {WrAddr, WrData};
    assign head_s     = head_vec_s;

    wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (CLK),
        .reset (Reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_vec_s),
        .dout  (head_vec_s),
        .count (count_s)
    );

    // Ready depends only on the registered count; pop/error come from the head decode.
    always_comb begin
        wr_ready_s  = (count_s < CNT_FULL);
        push_s      = WrValid && wr_ready_s;
        empty_s     = (count_s == CNT_ZERO);
        head_dest_s = decode_region(head_s.addr[WADDR_W-1:ADDR_W], IO_REGION);
        pop_s       = 1'b0;
        err_set_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // A memory entry stays at the head until its ack arrives.
                if (!empty_s) begin
                    pop_s     = (head_dest_s != DEST_MEM);
                    err_set_s = (head_dest_s == DEST_ERR);
                end else begin
                    pop_s     = 1'b0;
                    err_set_s = 1'b0;
                end
            end
            MEM_WAIT: begin
                if (MemAck) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: begin
                pop_s     = 1'b0;
                err_set_s = 1'b0;
            end
        endcase
    end

    // Dispatch FSM and all registered outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r     <= IDLE;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_data_r  <= {DATA_W{1'b0}};
            mem_we_r    <= 1'b0;
            io_out_r    <= {DATA_W{1'b0}};
            io_strobe_r <= 1'b0;
            addr_err_r  <= 1'b0;
        end else begin
            io_strobe_r <= 1'b0;

            // Set is evaluated after clear so a simultaneous new error wins.
            if (ErrClr) begin
                addr_err_r <= 1'b0;
            end
            if (err_set_s) begin
                addr_err_r <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        case (head_dest_s)
                            DEST_MEM: begin
                                state_r    <= MEM_WAIT;
                                mem_addr_r <= head_s.addr[ADDR_W-1:0];
                                mem_data_r <= head_s.data;
                                mem_we_r   <= 1'b1;
                            end
                            DEST_IO: begin
                                io_out_r    <= head_s.data;
                                io_strobe_r <= 1'b1;
                            end
                            default: begin
                                state_r <= IDLE;
                            end
                        endcase
                    end
                end
                MEM_WAIT: begin
                    // Address/data simply hold; only the ack ends the request.
                    if (MemAck) begin
                        mem_we_r <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    mem_we_r <= 1'b0;
                end
            endcase
        end
    end

    assign WrReady  = wr_ready_s;
    assign MemAddr  = mem_addr_r;
    assign MemData  = mem_data_r;
    assign MemWe    = mem_we_r;
    assign IOOut    = io_out_r;
    assign IOStrobe = io_strobe_r;
    assign AddrErr  = addr_err_r;

endmodule

// File: tb/tb_io_wr_demux.sv
// -----------------------------------------------------------------------------
// tb_io_wr_demux
// Directed bench for io_wr_demux (FIFO_DEPTH=2, IO_REGION=6'h3F). Inputs are
// driven 1 time unit after each rising edge and outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_io_wr_demux;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        WrValid;
    logic        WrReady;
    logic [15:0] WrAddr;
    logic [15:0] WrData;
    logic [9:0]  MemAddr;
    logic [15:0] MemData;
    logic        MemWe;
    logic        MemAck;
    logic [15:0] IOOut;
    logic        IOStrobe;
    logic        AddrErr;
    logic        ErrClr;

    logic        mem_ack_man;
    logic        auto_ack;
    logic        mon_en;
    logic [16:0] ret_q[$];
    int          strobe_n;
    int          n_cmp = 0;
    int          n_err = 0;

    assign MemAck = auto_ack ? MemWe : mem_ack_man;

    always #5 CLK = ~CLK;

    io_wr_demux #(
        .FIFO_DEPTH (2),
        .IO_REGION  (6'h3F)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .WrValid  (WrValid),
        .WrReady  (WrReady),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .MemAddr  (MemAddr),
        .MemData  (MemData),
        .MemWe    (MemWe),
        .MemAck   (MemAck),
        .IOOut    (IOOut),
        .IOStrobe (IOStrobe),
        .AddrErr  (AddrErr),
        .ErrClr   (ErrClr)
    );

    // Retirement log: {1=IO, data} or {0, memory address}, sampled mid-cycle.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (MemWe && MemAck) ret_q.push_back({1'b0, 6'h00, MemAddr});
            if (IOStrobe) begin
                ret_q.push_back({1'b1, IOOut});
                strobe_n++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        WrValid = 1'b1;
        WrAddr  = a;
        WrData  = d;
        tick();
        WrValid = 1'b0;
    endtask

    function automatic logic [16:0] ret_at(input int i);
        return (ret_q.size() > i) ? ret_q[i] : 17'h1FFFF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        Reset = 1'b1; WrValid = 1'b0; WrAddr = 16'h0000; WrData = 16'h0000;
        ErrClr = 1'b0; mem_ack_man = 1'b0; auto_ack = 1'b0; mon_en = 1'b0;
        strobe_n = 0;
        tick(); tick();
        Reset = 1'b0;
        tick();

        // Reset state
        chk("rst_wrready", WrReady, 1);
        chk("rst_memwe", MemWe, 0);
        chk("rst_memaddr", MemAddr, 0);
        chk("rst_memdata", MemData, 0);
        chk("rst_ioout", IOOut, 0);
        chk("rst_iostrobe", IOStrobe, 0);
        chk("rst_addrerr", AddrErr, 0);

        // Memory write, ack three cycles after MemWe rises
        wr(16'h0123, 16'hBEEF);                       // cycle N+1
        chk("mem_we_n1", MemWe, 0);
        tick();                                       // N+2
        chk("mem_we_n2", MemWe, 1);
        chk("mem_addr_n2", MemAddr, 10'h123);
        chk("mem_data_n2", MemData, 16'hBEEF);
        chk("mem_iostb_n2", IOStrobe, 0);
        tick();                                       // N+3
        chk("mem_we_hold", MemWe, 1);
        chk("mem_addr_hold", MemAddr, 10'h123);
        tick();                                       // N+4
        tick();                                       // N+5
        mem_ack_man = 1'b1;
        chk("mem_we_ackcyc", MemWe, 1);
        tick();                                       // N+6
        mem_ack_man = 1'b0;
        chk("mem_we_after_ack", MemWe, 0);
        chk("mem_ready_after", WrReady, 1);
        tick();
        chk("mem_single_pop", MemWe, 0);

        // IO write
        wr(16'hFC05, 16'h00A5);
        chk("io_stb_n1", IOStrobe, 0);
        tick();
        chk("io_stb_n2", IOStrobe, 1);
        chk("io_out_n2", IOOut, 16'h00A5);
        chk("io_memwe_n2", MemWe, 0);
        tick();
        chk("io_stb_n3", IOStrobe, 0);
        chk("io_out_n3", IOOut, 16'h00A5);
        chk("io_memwe_n3", MemWe, 0);

        // Unmapped address, clear/set collision, then clear alone
        wr(16'h0400, 16'h1234);
        chk("err_n1", AddrErr, 0);
        tick();
        chk("err_set", AddrErr, 1);
        chk("err_memwe", MemWe, 0);
        chk("err_iostb", IOStrobe, 0);
        tick();
        chk("err_sticky", AddrErr, 1);
        wr(16'h8000, 16'h1111);                       // decode cycle next
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        chk("err_set_wins", AddrErr, 1);
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        chk("err_clear", AddrErr, 0);

        // Full FIFO with ack held low
        WrValid = 1'b1; WrAddr = 16'h0011; WrData = 16'h1001;
        chk("full_rdy_a", WrReady, 1);
        tick();                                       // A+1
        WrAddr = 16'h0022; WrData = 16'h2002;
        chk("full_rdy_a1", WrReady, 1);
        tick();                                       // A+2
        WrAddr = 16'h0033; WrData = 16'h3003;
        chk("full_rdy_a2", WrReady, 0);
        chk("full_we_a2", MemWe, 1);
        chk("full_addr_a2", MemAddr, 10'h011);
        tick();                                       // A+3
        chk("full_rdy_a3", WrReady, 0);
        mem_ack_man = 1'b1;
        tick();                                       // A+4: third accepted here
        mem_ack_man = 1'b0;
        chk("full_rdy_a4", WrReady, 1);
        chk("full_we_a4", MemWe, 0);
        tick();                                       // A+5
        WrValid = 1'b0;
        chk("full_we_a5", MemWe, 1);
        chk("full_addr_a5", MemAddr, 10'h022);
        chk("full_data_a5", MemData, 16'h2002);
        chk("full_rdy_a5", WrReady, 0);
        mem_ack_man = 1'b1;
        tick();                                       // A+6
        mem_ack_man = 1'b0;
        chk("full_we_a6", MemWe, 0);
        tick();                                       // A+7
        chk("full_we_a7", MemWe, 1);
        chk("full_addr_a7", MemAddr, 10'h033);
        chk("full_data_a7", MemData, 16'h3003);
        mem_ack_man = 1'b1;
        tick();
        mem_ack_man = 1'b0;
        chk("full_we_done", MemWe, 0);
        tick();

        // Reset while waiting on memory with a second entry queued
        wr(16'h0044, 16'h4444);                       // B+1
        WrValid = 1'b1; WrAddr = 16'h0055; WrData = 16'h5555;
        tick();                                       // B+2
        WrValid = 1'b0;
        chk("rmid_we", MemWe, 1);
        chk("rmid_addr", MemAddr, 10'h044);
        Reset = 1'b1;
        tick();                                       // B+3
        Reset = 1'b0;
        chk("rmid_we_rst", MemWe, 0);
        chk("rmid_rdy_rst", WrReady, 1);
        chk("rmid_addr_rst", MemAddr, 0);
        chk("rmid_ioout_rst", IOOut, 0);
        mem_ack_man = 1'b1;
        tick();                                       // B+4
        mem_ack_man = 1'b0;
        chk("rmid_we_lateack", MemWe, 0);
        chk("rmid_rdy_lateack", WrReady, 1);
        wr(16'h0066, 16'h6666);
        tick();
        chk("rmid_new_we", MemWe, 1);
        chk("rmid_new_addr", MemAddr, 10'h066);
        chk("rmid_new_data", MemData, 16'h6666);
        mem_ack_man = 1'b1;
        tick();
        mem_ack_man = 1'b0;
        chk("rmid_new_done", MemWe, 0);
        tick();

        // Mixed stream with immediate ack
        auto_ack = 1'b1;
        mon_en   = 1'b1;
        ret_q.delete();
        strobe_n = 0;
        WrValid = 1'b1; WrAddr = 16'h0101; WrData = 16'h00A1;
        tick();                                       // C+1
        WrAddr = 16'hFC02; WrData = 16'h00B2;
        tick();                                       // C+2
        WrAddr = 16'h0203; WrData = 16'h00C3;
        chk("mix_rdy_c2", WrReady, 0);
        chk("mix_we_c2", MemWe, 1);
        chk("mix_addr_c2", MemAddr, 10'h101);
        tick();                                       // C+3: third accepted
        chk("mix_rdy_c3", WrReady, 1);
        chk("mix_we_c3", MemWe, 0);
        tick();                                       // C+4
        WrValid = 1'b0;
        chk("mix_stb_c4", IOStrobe, 1);
        chk("mix_io_c4", IOOut, 16'h00B2);
        tick();                                       // C+5
        chk("mix_we_c5", MemWe, 1);
        chk("mix_addr_c5", MemAddr, 10'h203);
        chk("mix_data_c5", MemData, 16'h00C3);
        chk("mix_stb_c5", IOStrobe, 0);
        tick(); tick(); tick();
        mon_en   = 1'b0;
        auto_ack = 1'b0;
        chk("mix_ret_count", ret_q.size(), 3);
        chk("mix_ret0", ret_at(0), 17'h00101);
        chk("mix_ret1", ret_at(1), 17'h100B2);
        chk("mix_ret2", ret_at(2), 17'h00203);
        chk("mix_strobes", strobe_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
